// File: rtl/sid_i2s_tx.sv
// Philips I2S transmitter for the SID mixer output: mono sample duplicated on both slots,
// one-entry holding register between the sample strobe and the free-running 64-BCLK frame.
module sid_i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        iRstN,
    input  logic [15:0] iSample,
    input  logic        iValid,
    output logic        oBclk,
    output logic        oLrclk,
    output logic        oSdata,
    output logic        oUnderrun,
    output logic        oOverrun
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic          r_bclk;
    logic [5:0]    r_bit_cnt;
    logic [15:0]   r_hold;
    logic [15:0]   r_frame;
    logic          r_fresh;
    logic          r_primed;
    logic          r_lrclk;
    logic          r_sdata;
    logic          r_underrun;
    logic          r_overrun;

    logic          w_wrap;
    logic          w_fall;
    logic [5:0]    w_bit_nxt;
    logic          w_load;
    logic [15:0]   w_frame_nxt;
    logic [4:0]    w_k;
    logic          w_bit;

    // Tick decode and the frame value as it will stand after a possible load.
    always_comb begin
        w_wrap    = (r_div_cnt == DIV_MAX);
        w_fall    = w_wrap && r_bclk;
        w_bit_nxt = r_bit_cnt + 6'd1;
        w_load    = w_fall && (w_bit_nxt == 6'd1);
        w_k       = r_bit_cnt[4:0];
        if (w_load && iValid) begin
            w_frame_nxt = iSample;
        end else if (w_load && r_fresh) begin
            w_frame_nxt = r_hold;
        end else begin
            w_frame_nxt = r_frame;
        end
        // Slot bit k = (n-1) mod 32 equals the old bit counter's low five bits.
        if (w_k < 5'd16) begin
            w_bit = w_frame_nxt[4'd15 - w_k[3:0]];
        end else begin
            w_bit = 1'b0;
        end
    end

    // BCLK divider and frame bit counter.
    always_ff @(posedge clk) begin
        if (!iRstN) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_bit_cnt <= 6'd0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
            if (r_bclk) begin
                r_bit_cnt <= w_bit_nxt;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    // Holding register, frame load and flag generation; an iValid on the load tick bypasses the hold.
    always_ff @(posedge clk) begin
        if (!iRstN) begin
            r_hold     <= 16'd0;
            r_frame    <= 16'd0;
            r_fresh    <= 1'b0;
            r_primed   <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
            if (w_load) begin
                r_frame <= w_frame_nxt;
                r_fresh <= 1'b0;
                if (iValid) begin
                    r_primed <= 1'b1;
                end else if (!r_fresh) begin
                    r_underrun <= r_primed;
                end else begin
                    r_primed <= r_primed;
                end
            end else if (iValid) begin
                r_hold    <= iSample;
                r_fresh   <= 1'b1;
                r_primed  <= 1'b1;
                r_overrun <= r_fresh;
            end else begin
                r_hold <= r_hold;
            end
        end
    end

    // Serial outputs change only on BCLK falling ticks.
    always_ff @(posedge clk) begin
        if (!iRstN) begin
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
        end else if (w_fall) begin
            r_lrclk <= w_bit_nxt[5];
            r_sdata <= w_bit;
        end else begin
            r_lrclk <= r_lrclk;
        end
    end

    assign oBclk     = r_bclk;
    assign oLrclk    = r_lrclk;
    assign oSdata    = r_sdata;
    assign oUnderrun = r_underrun;
    assign oOverrun  = r_overrun;

endmodule
